// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: one read or write frame per accepted request,
// preamble then 32 frame bits, with mdc generated from a clk divider.
module mdio_master #(
  parameter int unsigned CLK_DIV      = 20,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        ta_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  typedef enum logic [1:0] {StIdle, StPreamble, StFrame} state_e;

  localparam logic [7:0] DivTerm = 8'(CLK_DIV - 1);
  localparam logic [5:0] PreTerm = 6'(PREAMBLE_LEN - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic        mdc_q, mdc_d;
  logic        mdo_q, mdo_d;
  logic        mdt_q, mdt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ta_err_q, ta_err_d;
  logic [15:0] shift_q, shift_d;
  logic [31:0] frame_q, frame_d;
  logic        rd_q, rd_d;

  logic        tc;
  logic        mdc_rise;
  logic        mdc_fall;
  logic [5:0]  bit_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      div_q    <= 8'd0;
      bit_q    <= 6'd0;
      mdc_q    <= 1'b0;
      mdo_q    <= 1'b1;
      mdt_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 16'd0;
      ta_err_q <= 1'b0;
      shift_q  <= 16'd0;
      frame_q  <= 32'd0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      mdc_q    <= mdc_d;
      mdo_q    <= mdo_d;
      mdt_q    <= mdt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      ta_err_q <= ta_err_d;
      shift_q  <= shift_d;
      frame_q  <= frame_d;
      rd_q     <= rd_d;
    end
  end

  assign tc       = (div_q == DivTerm);
  assign mdc_rise = tc && !mdc_q;
  assign mdc_fall = tc && mdc_q;
  assign bit_nxt  = bit_q - 6'd1;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    mdc_d    = mdc_q;
    mdo_d    = mdo_q;
    mdt_d    = mdt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    ta_err_d = ta_err_q;
    shift_d  = shift_q;
    frame_d  = frame_q;
    rd_d     = rd_q;

    unique case (state_q)
      StIdle: begin
        div_d  = 8'd0;
        mdc_d  = 1'b0;
        mdo_d  = 1'b1;
        mdt_d  = 1'b1;
        busy_d = 1'b0;
        if (req) begin
          // Read frames carry all-ones in TA/data: those bits are released anyway.
          frame_d = {2'b01, (rw ? 2'b10 : 2'b01), phy_addr, reg_addr,
                     (rw ? 2'b11 : 2'b10), (rw ? 16'hffff : wdata)};
          rd_d    = rw;
          bit_d   = PreTerm;
          state_d = StPreamble;
          busy_d  = 1'b1;
          mdt_d   = 1'b0;
          mdo_d   = 1'b1;
        end
      end

      StPreamble, StFrame: begin
        if (tc) begin
          div_d = 8'd0;
          mdc_d = ~mdc_q;
        end else begin
          div_d = div_q + 8'd1;
        end

        if (mdc_rise && (state_q == StFrame) && rd_q) begin
          if (bit_q == 6'd16) begin
            ta_err_d = mdio_i;
          end else if (bit_q < 6'd16) begin
            shift_d = {shift_q[14:0], mdio_i};
          end
        end

        if (mdc_fall) begin
          if (state_q == StPreamble) begin
            mdt_d = 1'b0;
            if (bit_q == 6'd0) begin
              state_d = StFrame;
              bit_d   = 6'd31;
              mdo_d   = frame_q[31];
            end else begin
              bit_d = bit_nxt;
              mdo_d = 1'b1;
            end
          end else if (bit_q == 6'd0) begin
            state_d = StIdle;
            div_d   = 8'd0;
            mdc_d   = 1'b0;
            mdo_d   = 1'b1;
            mdt_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (rd_q) begin
              rdata_d = shift_q;
            end
          end else begin
            bit_d = bit_nxt;
            // Read releases the line from the first TA bit (17) onwards.
            mdt_d = rd_q && (bit_nxt <= 6'd17);
            mdo_d = mdt_d ? 1'b1 : frame_q[bit_nxt[4:0]];
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign ta_err = ta_err_q;
  assign mdc    = mdc_q;
  assign mdio_o = mdo_q;
  assign mdio_t = mdt_q;

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: expected frames are queued at issue time and
// compared by a monitor at each done pulse; includes a small virtual-PHY responder.
module tb_mdio_master;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] tmask;
    logic [15:0] rdata;
    logic        ta_err;
    int          lat;
    int          nbits;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req, rw;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] wdata;
  logic        busy, done, ta_err, mdc, mdio_o, mdio_t;
  logic [15:0] rdata;
  logic        mdio_i;

  logic        req6, rw6;
  logic [4:0]  phy_addr6, reg_addr6;
  logic [15:0] wdata6;
  logic        busy6, done6, ta_err6, mdc6, mdio_o6, mdio_t6;
  logic [15:0] rdata6;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .ta_err(ta_err), .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(255), .PREAMBLE_LEN(1)) dut6 (
    .clk(clk), .reset(reset), .req(req6), .rw(rw6), .phy_addr(phy_addr6),
    .reg_addr(reg_addr6), .wdata(wdata6), .busy(busy6), .done(done6), .rdata(rdata6),
    .ta_err(ta_err6), .mdc(mdc6), .mdio_o(mdio_o6), .mdio_t(mdio_t6), .mdio_i(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  exp_t q6[$];

  logic        phy_en = 1'b0;
  logic [15:0] phy_data = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor state for the main DUT
  int          nrise = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  logic [63:0] cap_o = '0, cap_t = '0;
  logic        prev_mdc = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;

  // Monitor state for the slow DUT
  int          nrise6 = 0, start6 = 0, rise0_cyc = 0, per6 = 0, done6_cnt = 0;
  logic [63:0] cap6 = '0;
  logic        prev_mdc6 = 1'b0, prev_busy6 = 1'b0;

  initial mdio_i = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    int nb;
    if (!reset) begin
      nrise = 0; cap_o = '0; cap_t = '0; mdio_i = 1'b1;
      prev_mdc = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", {63'd0, done}, 64'd0);
      if (busy && !prev_busy) start_cyc = cyc;
      if (mdc && !prev_mdc) begin
        cap_o = {cap_o[62:0], mdio_o};
        cap_t = {cap_t[62:0], mdio_t};
        // Virtual PHY: present the next bit's value right after this rise.
        nb = 63 - nrise - 1;
        nrise++;
        if (phy_en && nb == 16) mdio_i = 1'b0;
        else if (phy_en && nb >= 0 && nb < 16) mdio_i = phy_data[nb];
        else mdio_i = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("frame_bits", cap_o, e.bits);
          check("mdio_t_mask", cap_t, e.tmask);
          check("bit_count", 64'(nrise), 64'(e.nbits));
          check("rdata", {48'd0, rdata}, {48'd0, e.rdata});
          check("ta_err", {63'd0, ta_err}, {63'd0, e.ta_err});
          check("latency", 64'(cyc - start_cyc + 1), 64'(e.lat));
        end
        nrise = 0; cap_o = '0; cap_t = '0; mdio_i = 1'b1;
      end
      prev_mdc = mdc; prev_busy = busy; prev_done = done;
    end

    if (reset) begin
      if (busy6 && !prev_busy6) start6 = cyc;
      if (mdc6 && !prev_mdc6) begin
        cap6 = {cap6[62:0], mdio_o6};
        if (nrise6 == 0) rise0_cyc = cyc;
        if (nrise6 == 1) per6 = cyc - rise0_cyc;
        nrise6++;
      end
      if (done6) begin
        done6_cnt++;
        if (q6.size() == 0) begin
          check("unexpected_done6", 64'd1, 64'd0);
        end else begin
          e = q6.pop_front();
          check("slow_bits", cap6 & ((64'd1 << e.nbits) - 64'd1), e.bits);
          check("slow_bit_count", 64'(nrise6), 64'(e.nbits));
          check("slow_mdc_period", 64'(per6), 64'd510);
          check("slow_latency", 64'(cyc - start6 + 1), 64'(e.lat));
        end
      end
      prev_mdc6 = mdc6; prev_busy6 = busy6;
    end
  end

  task automatic issue(input logic r, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic push, input exp_t e);
    rw = r; phy_addr = pa; reg_addr = ra; wdata = wd; req = 1'b1;
    if (push) q.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int b = budget;
    while (done_cnt < target && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (done_cnt < target) check("timeout_frames", 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_rises(input int n, input int budget);
    int b = budget;
    while (nrise < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (nrise < n) check("timeout_rises", 64'(nrise), 64'(n));
  endtask

  function automatic exp_t mk(input logic [31:0] frame, input logic rd,
                              input logic [15:0] rdv, input logic ta);
    exp_t e;
    e.bits   = {32'hffff_ffff, frame};
    e.tmask  = rd ? 64'h3_ffff : 64'd0;
    e.rdata  = rdv;
    e.ta_err = ta;
    e.lat    = 257;
    e.nbits  = 64;
    return e;
  endfunction

  initial begin
    exp_t e6;
    int b;
    reset = 1'b0; req = 1'b0; rw = 1'b0; phy_addr = '0; reg_addr = '0; wdata = '0;
    req6 = 1'b0; rw6 = 1'b0; phy_addr6 = '0; reg_addr6 = '0; wdata6 = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {57'd0, mdc, mdio_o, mdio_t, busy, done, ta_err, |rdata},
          {57'd0, 7'b0110000});
    reset = 1'b1;
    @(negedge clk);

    // Write phy 1 reg 0 = 1040
    issue(1'b0, 5'd1, 5'd0, 16'h1040, 1'b1, mk(32'h5082_1040, 1'b0, 16'h0000, 1'b0));
    wait_frames(1, 400);

    // Read phy 1 reg 2 from the virtual PHY
    phy_en = 1'b1; phy_data = 16'h7e19;
    issue(1'b1, 5'd1, 5'd2, 16'h0, 1'b1, mk(32'h608b_ffff, 1'b1, 16'h7e19, 1'b0));
    wait_frames(2, 400);

    // Read with no PHY attached
    phy_en = 1'b0;
    issue(1'b1, 5'd3, 5'd1, 16'h0, 1'b1, mk(32'h6187_ffff, 1'b1, 16'hffff, 1'b1));
    wait_frames(3, 400);

    // Ignored mid-frame request, then back-to-back request in the done cycle
    issue(1'b0, 5'd2, 5'd4, 16'ha5c3, 1'b1, mk(32'h5112_a5c3, 1'b0, 16'hffff, 1'b1));
    wait_rises(20, 400);
    rw = 1'b1; phy_addr = 5'd31; reg_addr = 5'd31; wdata = 16'h0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    b = 400;
    while (!done && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    phy_en = 1'b1; phy_data = 16'h1234;
    issue(1'b1, 5'd1, 5'd2, 16'h0, 1'b1, mk(32'h608b_ffff, 1'b1, 16'h1234, 1'b0));
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_frames(5, 400);

    // Reset during bit 40 of a read
    phy_data = 16'h5555;
    issue(1'b1, 5'd1, 5'd2, 16'h0, 1'b0, mk(32'h0, 1'b1, 16'h0, 1'b0));
    wait_rises(40, 400);
    reset = 1'b0;
    #1;
    check("abort_state", {44'd0, mdc, mdio_t, busy, done, rdata},
          {44'd0, 4'b0100, 16'h0000});
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(1'b0, 5'd1, 5'd0, 16'h1040, 1'b1, mk(32'h5082_1040, 1'b0, 16'h0000, 1'b0));
    wait_frames(6, 400);

    // One preamble bit, slow mdc
    e6.bits = {31'd0, 1'b1, 32'h528e_beef}; e6.tmask = '0; e6.rdata = '0;
    e6.ta_err = 1'b0; e6.lat = 1 + 510 * 33; e6.nbits = 33;
    q6.push_back(e6);
    rw6 = 1'b0; phy_addr6 = 5'd5; reg_addr6 = 5'd3; wdata6 = 16'hbeef; req6 = 1'b1;
    @(negedge clk);
    req6 = 1'b0;
    b = 20000;
    while (done6_cnt < 1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (done6_cnt < 1) check("timeout_slow", 64'(done6_cnt), 64'd1);
    repeat (2) @(negedge clk);
    check("queues_empty", 64'(q.size() + q6.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
